// File: rtl/robo_controller.sv
// Left-hand wall-following navigation FSM for the Memo maze map.
// Registered command strobes; terminal DONE/ERROR states exit only on reset.
module robo_controller #(
    parameter int SETTLE_CYCLES     = 1,
    parameter int MAX_STEPS         = 255,
    parameter int MAX_REMOVE_CYCLES = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       head_in,
    input  logic       left_in,
    input  logic       under_in,
    input  logic       barrier_in,
    output logic       avancar,
    output logic       girar,
    output logic       remover,
    output logic       done,
    output logic       error,
    output logic [7:0] step_count,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SENSE   = 4'd1,
        TURN_L  = 4'd2,
        TURN_R  = 4'd3,
        ADVANCE = 4'd4,
        REMOVE  = 4'd5,
        SETTLE  = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [7:0] cnt;
    logic [7:0] cnt_d;
    logic [7:0] step_d;
    logic       left_turned;
    logic       left_turned_d;

    always_comb begin
        state_d       = state;
        step_d        = step_count;
        left_turned_d = left_turned;
        unique case (state)
            IDLE: begin
                if (enable) state_d = SENSE;
            end
            SENSE: begin
                if (!enable)                         state_d = IDLE;
                else if (under_in)                   state_d = DONE;
                else if (!left_turned && !left_in)   state_d = TURN_L;
                else if (barrier_in)                 state_d = REMOVE;
                else if (!head_in)                   state_d = ADVANCE;
                else                                 state_d = TURN_R;
                if (state_d == ADVANCE) step_d = step_count + 8'd1;
            end
            TURN_L: begin
                left_turned_d = 1'b1;
                state_d       = SETTLE;
            end
            // three CCW rotations make one CW quarter turn
            TURN_R: begin
                if (cnt == 8'd2) state_d = SETTLE;
            end
            ADVANCE: begin
                left_turned_d = 1'b0;
                if (step_count == 8'(MAX_STEPS)) state_d = ERROR;
                else                             state_d = SETTLE;
            end
            REMOVE: begin
                if (!barrier_in)
                    state_d = SETTLE;
                else if (cnt == 8'(MAX_REMOVE_CYCLES - 1))
                    state_d = ERROR;
            end
            SETTLE: begin
                if (cnt == 8'(SETTLE_CYCLES - 1)) state_d = SENSE;
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
        // dwell counter restarts on every state change
        cnt_d = (state_d == state) ? cnt + 8'd1 : 8'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            left_turned <= 1'b0;
            step_count  <= 8'd0;
            avancar     <= 1'b0;
            girar       <= 1'b0;
            remover     <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            state_out   <= 4'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            left_turned <= left_turned_d;
            step_count  <= step_d;
            avancar     <= (state_d == ADVANCE);
            girar       <= (state_d == TURN_L) || (state_d == TURN_R);
            remover     <= (state_d == REMOVE);
            done        <= (state_d == DONE);
            error       <= (state_d == ERROR);
            state_out   <= state_d;
        end
    end

endmodule

// File: tb/tb_robo_controller.sv
// Directed bench for robo_controller, including a small closed-loop maze.
// Sensors come from directed drivers or from a 3x3 grid model.
module tb_robo_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       head_in, left_in, under_in, barrier_in;
    logic       avancar, girar, remover, done, error;
    logic [7:0] step_count;
    logic [3:0] state_out;
    logic       avancar4, girar4, remover4, done4, error4;
    logic [7:0] step_count4;
    logic [3:0] state_out4;

    logic d_head, d_left, d_under, d_barrier;
    logic loop_mode;
    logic m_head, m_left, m_under;
    int   mx, my, md;
    int   n_vec = 0;
    int   n_bad = 0;
    int   hi;
    int   onehot_bad;

    always #5 clock = ~clock;

    assign head_in    = loop_mode ? m_head  : d_head;
    assign left_in    = loop_mode ? m_left  : d_left;
    assign under_in   = loop_mode ? m_under : d_under;
    assign barrier_in = loop_mode ? 1'b0    : d_barrier;

    robo_controller u_dut (
        .clock(clock), .reset(reset), .enable(enable),
        .head_in(head_in), .left_in(left_in),
        .under_in(under_in), .barrier_in(barrier_in),
        .avancar(avancar), .girar(girar), .remover(remover),
        .done(done), .error(error),
        .step_count(step_count), .state_out(state_out)
    );

    robo_controller #(.MAX_STEPS(4)) u_dut4 (
        .clock(clock), .reset(reset), .enable(enable),
        .head_in(head_in), .left_in(left_in),
        .under_in(under_in), .barrier_in(barrier_in),
        .avancar(avancar4), .girar(girar4), .remover(remover4),
        .done(done4), .error(error4),
        .step_count(step_count4), .state_out(state_out4)
    );

    // open cells: (0,0) (1,0) (2,0) (2,1) (2,2); goal at (2,2)
    function automatic logic is_open(input int x, input int y);
        logic [8:0] open_map;
        open_map = 9'h127;
        if (x < 0 || x > 2 || y < 0 || y > 2) return 1'b0;
        return open_map[y*3 + x];
    endfunction

    function automatic int dxf(input int d);
        return (d == 0) ? 1 : ((d == 2) ? -1 : 0);
    endfunction

    function automatic int dyf(input int d);
        return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
    endfunction

    always_comb begin
        m_head  = !is_open(mx + dxf(md), my + dyf(md));
        m_left  = !is_open(mx + dxf((md + 1) % 4), my + dyf((md + 1) % 4));
        m_under = (mx == 2) && (my == 2);
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mx <= 0; my <= 0; md <= 0;
        end else if (loop_mode) begin
            if (avancar) begin
                mx <= mx + dxf(md);
                my <= my + dyf(md);
            end
            if (girar) md <= (md + 1) % 4;
        end
    end

    task automatic do_reset;
        reset = 1'b0; enable = 1'b0; loop_mode = 1'b0;
        d_head = 1'b0; d_left = 1'b1; d_under = 1'b0; d_barrier = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++;
        if ({avancar, girar, remover, done, error, step_count, state_out} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_values got %h want 0",
                     {avancar, girar, remover, done, error, step_count, state_out});
        end
        d_head = 1'b1; d_left = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++;
        if (girar !== 1'b1 || state_out !== 4'd3) begin
            n_bad++;
            $display("FAIL turn_r_entry got girar=%b st=%0d want 1/3", girar, state_out);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({avancar, girar, remover, done, error, step_count, state_out} !== 17'd0) begin
            n_bad++;
            $display("FAIL async_reset got %h want 0",
                     {avancar, girar, remover, done, error, step_count, state_out});
        end
    endtask

    task automatic test_advance;
        do_reset();
        d_head = 1'b0; d_left = 1'b1; enable = 1'b1;
        @(negedge clock);
        n_vec++;
        if (state_out !== 4'd1 || avancar !== 1'b0) begin
            n_bad++;
            $display("FAIL adv_sense got st=%0d av=%b want 1/0", state_out, avancar);
        end
        @(negedge clock);
        n_vec++;
        if (state_out !== 4'd4 || avancar !== 1'b1 || step_count !== 8'd1) begin
            n_bad++;
            $display("FAIL adv_pulse got st=%0d av=%b sc=%0d want 4/1/1",
                     state_out, avancar, step_count);
        end
        @(negedge clock);
        n_vec++;
        if (state_out !== 4'd6 || avancar !== 1'b0) begin
            n_bad++;
            $display("FAIL adv_settle got st=%0d av=%b want 6/0", state_out, avancar);
        end
        @(negedge clock);
        n_vec++;
        if (state_out !== 4'd1) begin
            n_bad++;
            $display("FAIL adv_resense got st=%0d want 1", state_out);
        end
        enable = 1'b0;
        @(negedge clock);
        n_vec++;
        if (state_out !== 4'd0 || step_count !== 8'd1) begin
            n_bad++;
            $display("FAIL adv_park got st=%0d sc=%0d want 0/1", state_out, step_count);
        end
    endtask

    task automatic test_turn_left;
        do_reset();
        d_head = 1'b0; d_left = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++;
        if (state_out !== 4'd2 || girar !== 1'b1) begin
            n_bad++;
            $display("FAIL tl_pulse got st=%0d g=%b want 2/1", state_out, girar);
        end
        @(negedge clock);
        n_vec++;
        if (girar !== 1'b0 || state_out !== 4'd6) begin
            n_bad++;
            $display("FAIL tl_single got st=%0d g=%b want 6/0", state_out, girar);
        end
        repeat (2) @(negedge clock);
        n_vec++;
        if (state_out !== 4'd4 || avancar !== 1'b1) begin
            n_bad++;
            $display("FAIL tl_then_adv got st=%0d av=%b want 4/1", state_out, avancar);
        end
        repeat (3) @(negedge clock);
        n_vec++;
        if (state_out !== 4'd2 || girar !== 1'b1) begin
            n_bad++;
            $display("FAIL tl_cleared got st=%0d g=%b want 2/1", state_out, girar);
        end
        enable = 1'b0;
    endtask

    task automatic test_turn_right;
        do_reset();
        d_head = 1'b1; d_left = 1'b1; enable = 1'b1;
        @(negedge clock);
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (girar === 1'b1 && state_out === 4'd3) hi++;
        end
        n_vec++;
        if (hi !== 3) begin
            n_bad++;
            $display("FAIL tr_cycles got %0d want 3", hi);
        end
        @(negedge clock);
        n_vec++;
        if (girar !== 1'b0 || state_out !== 4'd6) begin
            n_bad++;
            $display("FAIL tr_settle got st=%0d g=%b want 6/0", state_out, girar);
        end
        enable = 1'b0;
    endtask

    task automatic test_remove;
        do_reset();
        d_head = 1'b1; d_left = 1'b1; d_barrier = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clock);
        hi = (remover === 1'b1) ? 1 : 0;
        enable = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            @(posedge clock);
            #1;
            if (k == 10) d_barrier = 1'b0;
            @(negedge clock);
            if (remover === 1'b1) hi++;
        end
        n_vec++;
        if (hi !== 10 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_clear got cycles=%0d err=%b want 10/0", hi, error);
        end

        do_reset();
        d_head = 1'b1; d_left = 1'b1; d_barrier = 1'b1; enable = 1'b1;
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (remover === 1'b1) hi++;
            if (error === 1'b1) break;
        end
        n_vec++;
        if (hi !== 15 || error !== 1'b1 || state_out !== 4'd8 || remover !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_stuck got cycles=%0d err=%b st=%0d rm=%b want 15/1/8/0",
                     hi, error, state_out, remover);
        end
        d_barrier = 1'b0;
        repeat (5) @(negedge clock);
        n_vec++;
        if (error !== 1'b1 || state_out !== 4'd8) begin
            n_bad++;
            $display("FAIL rm_sticky got err=%b st=%0d want 1/8", error, state_out);
        end
    endtask

    task automatic test_done_and_limit;
        do_reset();
        d_under = 1'b1; d_head = 1'b0; d_left = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++;
        if (done !== 1'b1 || state_out !== 4'd7 || {avancar, girar, remover} !== 3'b000) begin
            n_bad++;
            $display("FAIL done_entry got d=%b st=%0d strobes=%b want 1/7/000",
                     done, state_out, {avancar, girar, remover});
        end
        d_under = 1'b0;
        repeat (5) @(negedge clock);
        n_vec++;
        if (done !== 1'b1 || state_out !== 4'd7 || {avancar, girar, remover} !== 3'b000) begin
            n_bad++;
            $display("FAIL done_sticky got d=%b st=%0d strobes=%b want 1/7/000",
                     done, state_out, {avancar, girar, remover});
        end

        do_reset();
        d_head = 1'b0; d_left = 1'b1; enable = 1'b1;
        hi = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (avancar4 === 1'b1) hi++;
            if (error4 === 1'b1) break;
        end
        n_vec++;
        if (hi !== 4 || step_count4 !== 8'd4 || error4 !== 1'b1 || state_out4 !== 4'd8) begin
            n_bad++;
            $display("FAIL step_limit got pulses=%0d sc=%0d err=%b st=%0d want 4/4/1/8",
                     hi, step_count4, error4, state_out4);
        end
    endtask

    task automatic test_closed_loop;
        do_reset();
        loop_mode = 1'b1;
        enable = 1'b1;
        onehot_bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if ((32'(avancar) + 32'(girar) + 32'(remover)) > 1) onehot_bad++;
            if (done === 1'b1 || error === 1'b1) break;
        end
        n_vec++;
        if (done !== 1'b1 || error !== 1'b0 || step_count !== 8'd4) begin
            n_bad++;
            $display("FAIL maze_goal got d=%b e=%b sc=%0d want 1/0/4",
                     done, error, step_count);
        end
        n_vec++;
        if (onehot_bad !== 0) begin
            n_bad++;
            $display("FAIL strobe_onehot got %0d overlaps want 0", onehot_bad);
        end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_turn_left();
        test_turn_right();
        test_remove();
        test_done_and_limit();
        test_closed_loop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
